hour_encoder: RTL and testbench
===============================

// Module: hour_encoder
// PURPOSE
//  Hour-setting entry block: takes debounced hour buttons in 12h (hour + AM/PM) or 24h form,
//  holds the edited value and emits a 24h hour (0..23) on commit. Inverse of the 24h->12h display
//  decoder; feeds the alarm/clock hour registers, while disp_* drive the display path during edit.
// PARAMETERS
//  RESET_HOUR  0  24h hour loaded into hour_out at reset (0..23)
// PORTS
//  clk              in   1  system clock, all state on rising edge
//  reset            in   1  asynchronous, active-high reset
//  two_four_format  in   1  1 = 24h entry, 0 = 12h entry; sampled only on start
//  hour_in          in   6  current 24h hour, edit seed; sampled only on start
//  start_btn        in   1  debounced level; rising edge enters EDIT
//  inc_btn          in   1  debounced level; rising edge = hour +1
//  dec_btn          in   1  debounced level; rising edge = hour -1
//  ampm_btn         in   1  debounced level; rising edge toggles PM (12h edit only)
//  commit_btn       in   1  debounced level; rising edge accepts edit
//  cancel_btn       in   1  debounced level; rising edge abandons edit
//  editing          out  1  high while in EDIT
//  disp_hour        out  6  edited hour in entry format (1..12 or 0..23)
//  disp_pm          out  1  edited PM flag (0 in 24h edit)
//  hour_out         out  6  last committed 24h hour
//  hour_valid       out  1  one-cycle pulse when hour_out updates
// BEHAVIOUR
//  Interface: one clock; reset is asynchronous and active-high (clk, reset).
//  Reset: state=IDLE, editing=0, hour_valid=0, hour_out=RESET_HOUR, disp_hour=0, disp_pm=0,
//   fmt latch=0, all button history regs=1 (buttons held through reset give no edge).
//  Edge detect: edge = btn & ~btn_q; acts at the clock edge where btn is first sampled high;
//   effect visible on outputs right after that edge. Held buttons act once.
//  FSM IDLE: start edge -> EDIT; latch fmt=two_four_format; seed from hour_in:
//   24h: disp_hour=hour_in, disp_pm=0. 12h: 0->12 AM, 1..11->h AM, 12->12 PM, 13..23->h-12 PM.
//   hour_in>23 seeds as 0 (24h) / 12 AM (12h). Other buttons ignored in IDLE.
//  FSM EDIT: editing=1. 24h: inc 23->0 wrap, dec 0->23 wrap. 12h: inc 12->1, dec 1->12,
//   hour wrap never changes disp_pm; ampm edge toggles disp_pm (ignored in 24h).
//   inc and dec same cycle: no change. start edge ignored. two_four_format changes ignored.
//   commit edge -> COMMIT; cancel edge -> IDLE, hour_out unchanged, no pulse.
//   cancel and commit same cycle: cancel wins. commit with inc/dec/ampm same cycle: commit wins,
//   pre-edit value used, other edges dropped.
//  FSM COMMIT (1 cycle): hour_out <= encode(disp), hour_valid=1 this cycle only, then IDLE.
//   Encode 12h: 12 AM->0, h AM->h, 12 PM->12, h PM->h+12. 24h: unchanged.
//   Latency commit edge -> hour_valid/hour_out: 1 cycle; editing drops in the COMMIT cycle.
//  IDLE: disp_hour/disp_pm hold last edited value.
//  Reset mid-EDIT/COMMIT: immediate return to reset values; no hour_valid pulse.
//  Width: all hour arithmetic 6 bit; no result outside 0..23 (24h) or 1..12 (12h).
// TESTING
//  Reset, RESET_HOUR=7 -> hour_out=7, hour_valid=0, editing=0; held inc_btn over reset gives no edge.
//  12h: hour_in=0, start -> disp 12/AM; inc x1 -> 1 AM; ampm -> 1 PM; commit -> hour_out=13, 1-cycle pulse.
//  12h wrap: hour_in=23 -> 11 PM; inc -> 12 PM; inc -> 1 PM; dec x2 -> 12 PM -> 11 PM; commit -> 23.
//  24h: hour_in=0, dec -> 23; inc -> 0; ampm ignored (disp_pm=0); commit -> hour_out=0.
//  Simultaneous: inc+dec same cycle -> no change; commit+inc -> pre-inc value; cancel+commit -> IDLE.
//  Cancel/reset: edit to 5, cancel -> hour_out unchanged; reset mid-EDIT -> IDLE, no pulse.

Source files
------------

// File: rtl/hour_encoder.sv
// Hour-setting entry block: edits an hour in 12h or 24h form from debounced buttons
// and publishes the committed value as a 24h hour with a one-cycle valid pulse.
module hour_encoder #(
  parameter logic [5:0] RESET_HOUR = 6'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       two_four_format,
  input  logic [5:0] hour_in,
  input  logic       start_btn,
  input  logic       inc_btn,
  input  logic       dec_btn,
  input  logic       ampm_btn,
  input  logic       commit_btn,
  input  logic       cancel_btn,
  output logic       editing,
  output logic [5:0] disp_hour,
  output logic       disp_pm,
  output logic [5:0] hour_out,
  output logic       hour_valid
);

  typedef enum logic [1:0] {IDLE, EDIT, COMMIT} state_t;

  state_t     state_reg, state_next;
  logic [5:0] btn_now, btn_q_reg, btn_edge;
  logic       start_edge, inc_edge, dec_edge, ampm_edge, commit_edge, cancel_edge;
  logic       fmt_reg, fmt_next;
  logic [5:0] hour_reg, hour_next;
  logic       pm_reg, pm_next;
  logic [5:0] out_reg, out_next;
  logic [5:0] seed_base, seed_hour, inc_hour, dec_hour, enc_hour;
  logic       seed_pm;

  assign btn_now     = {cancel_btn, commit_btn, ampm_btn, dec_btn, inc_btn, start_btn};
  assign btn_edge    = btn_now & ~btn_q_reg;
  assign start_edge  = btn_edge[0];
  assign inc_edge    = btn_edge[1];
  assign dec_edge    = btn_edge[2];
  assign ampm_edge   = btn_edge[3];
  assign commit_edge = btn_edge[4];
  assign cancel_edge = btn_edge[5];

  // Out-of-range hour_in is treated as midnight when seeding.
  always_comb begin
    seed_base = (hour_in <= 6'd23) ? hour_in : 6'd0;
    seed_hour = seed_base;
    seed_pm   = 1'b0;
    if (!two_four_format) begin
      if (seed_base == 6'd0) begin
        seed_hour = 6'd12;
      end else if (seed_base == 6'd12) begin
        seed_pm   = 1'b1;
      end else if (seed_base > 6'd12) begin
        seed_hour = seed_base - 6'd12;
        seed_pm   = 1'b1;
      end
    end
  end

  always_comb begin
    if (fmt_reg) begin
      inc_hour = (hour_reg >= 6'd23) ? 6'd0 : hour_reg + 6'd1;
      dec_hour = (hour_reg == 6'd0 || hour_reg > 6'd23) ? 6'd23 : hour_reg - 6'd1;
      enc_hour = hour_reg;
    end else begin
      inc_hour = (hour_reg >= 6'd12) ? 6'd1 : hour_reg + 6'd1;
      dec_hour = (hour_reg <= 6'd1 || hour_reg > 6'd12) ? 6'd12 : hour_reg - 6'd1;
      if (hour_reg == 6'd12)
        enc_hour = pm_reg ? 6'd12 : 6'd0;
      else
        enc_hour = pm_reg ? hour_reg + 6'd12 : hour_reg;
    end
  end

  always_comb begin
    state_next = state_reg;
    fmt_next   = fmt_reg;
    hour_next  = hour_reg;
    pm_next    = pm_reg;
    out_next   = out_reg;
    case (state_reg)
      IDLE: begin
        if (start_edge) begin
          state_next = EDIT;
          fmt_next   = two_four_format;
          hour_next  = seed_hour;
          pm_next    = seed_pm;
        end
      end
      EDIT: begin
        // Cancel beats commit; commit beats any same-cycle edit.
        if (cancel_edge) begin
          state_next = IDLE;
        end else if (commit_edge) begin
          state_next = COMMIT;
          out_next   = enc_hour;
        end else begin
          if (inc_edge && !dec_edge) hour_next = inc_hour;
          if (dec_edge && !inc_edge) hour_next = dec_hour;
          if (ampm_edge && !fmt_reg) pm_next = ~pm_reg;
        end
      end
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // History regs reset high so buttons held through reset do not produce an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      btn_q_reg <= '1;
      fmt_reg   <= 1'b0;
      hour_reg  <= 6'd0;
      pm_reg    <= 1'b0;
      out_reg   <= RESET_HOUR;
    end else begin
      state_reg <= state_next;
      btn_q_reg <= btn_now;
      fmt_reg   <= fmt_next;
      hour_reg  <= hour_next;
      pm_reg    <= pm_next;
      out_reg   <= out_next;
    end
  end

  assign editing    = (state_reg == EDIT);
  assign hour_valid = (state_reg == COMMIT);
  assign disp_hour  = hour_reg;
  assign disp_pm    = pm_reg;
  assign hour_out   = out_reg;

endmodule

// File: tb/tb_hour_encoder.sv
// Bench for hour_encoder: directed scenarios plus randomized buttons, all outputs
// compared every cycle against an arithmetic reference model.
module tb_hour_encoder;

  localparam int START = 1, INC = 2, DEC = 4, AMPM = 8, COMMIT = 16, CANCEL = 32;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       two_four_format = 1'b0;
  logic [5:0] hour_in = 6'd0;
  logic [5:0] btn = 6'b000011;
  logic       editing, disp_pm, hour_valid;
  logic [5:0] disp_hour, hour_out;

  int n_checks = 0;
  int n_fail = 0;

  // Reference model: mode 0 idle, 1 editing, 2 commit cycle.
  int m_mode, m_h, m_pm, m_fmt24, m_out;
  bit [5:0] m_q;

  always #5 clk = ~clk;

  hour_encoder #(.RESET_HOUR(6'd7)) dut (
    .clk(clk), .reset(reset), .two_four_format(two_four_format), .hour_in(hour_in),
    .start_btn(btn[0]), .inc_btn(btn[1]), .dec_btn(btn[2]), .ampm_btn(btn[3]),
    .commit_btn(btn[4]), .cancel_btn(btn[5]),
    .editing(editing), .disp_hour(disp_hour), .disp_pm(disp_pm),
    .hour_out(hour_out), .hour_valid(hour_valid)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int to24(input int h, input int pm, input int fmt24);
    return fmt24 ? h : (h % 12) + (pm ? 12 : 0);
  endfunction

  task automatic model_reset();
    m_mode = 0; m_h = 0; m_pm = 0; m_fmt24 = 0; m_out = 7; m_q = '1;
  endtask

  task automatic model_clock();
    bit [5:0] e;
    int h;
    e   = btn & ~m_q;
    m_q = btn;
    if (m_mode == 2) begin
      m_mode = 0;
    end else if (m_mode == 0) begin
      if (e[0]) begin
        m_mode  = 1;
        m_fmt24 = two_four_format;
        h       = (hour_in > 23) ? 0 : int'(hour_in);
        if (m_fmt24) begin
          m_h = h; m_pm = 0;
        end else begin
          m_pm = (h >= 12);
          m_h  = (h % 12 == 0) ? 12 : h % 12;
        end
      end
    end else begin
      if (e[5]) begin
        m_mode = 0;
      end else if (e[4]) begin
        m_out  = to24(m_h, m_pm, m_fmt24);
        m_mode = 2;
      end else begin
        if (e[1] && !e[2]) m_h = m_fmt24 ? (m_h + 1) % 24 : m_h % 12 + 1;
        if (e[2] && !e[1]) m_h = m_fmt24 ? (m_h + 23) % 24 : (m_h + 10) % 12 + 1;
        if (e[3] && !m_fmt24) m_pm = !m_pm;
      end
    end
  endtask

  task automatic compare_all();
    check_eq("editing", int'(editing), int'(m_mode == 1));
    check_eq("hour_valid", int'(hour_valid), int'(m_mode == 2));
    check_eq("disp_hour", int'(disp_hour), m_h);
    check_eq("disp_pm", int'(disp_pm), m_pm);
    check_eq("hour_out", int'(hour_out), m_out);
  endtask

  task automatic step();
    @(posedge clk);
    model_clock();
    @(negedge clk);
    compare_all();
  endtask

  task automatic hit(input int mask);
    btn = mask[5:0];
    step();
  endtask

  task automatic rel();
    btn = '0;
    step();
  endtask

  // Reset asserted between clock edges must clear outputs immediately.
  task automatic mid_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    model_reset();
    #1 compare_all();
    check_eq("rst_async_editing", int'(editing), 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    compare_all();
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    compare_all();
    check_eq("reset_hour_out", int'(hour_out), 7);
    check_eq("reset_valid", int'(hour_valid), 0);
    repeat (3) step();
    check_eq("held_btn_no_edge", int'(editing), 0);
    rel();

    // 12h: midnight seed, inc, ampm, commit
    two_four_format = 1'b0; hour_in = 6'd0;
    hit(START); rel();
    check_eq("12h_seed_hour", int'(disp_hour), 12);
    check_eq("12h_seed_pm", int'(disp_pm), 0);
    hit(INC); rel();
    check_eq("12h_inc", int'(disp_hour), 1);
    hit(AMPM); rel();
    check_eq("12h_ampm", int'(disp_pm), 1);
    hit(COMMIT);
    check_eq("12h_commit_valid", int'(hour_valid), 1);
    check_eq("12h_commit_out", int'(hour_out), 13);
    check_eq("12h_commit_editing", int'(editing), 0);
    rel();
    check_eq("valid_one_cycle", int'(hour_valid), 0);

    // 12h wrap around noon
    hour_in = 6'd23;
    hit(START); rel();
    check_eq("wrap_seed", int'(disp_hour), 11);
    hit(INC); rel();
    check_eq("wrap_inc12", int'(disp_hour), 12);
    hit(INC); rel();
    check_eq("wrap_inc1", int'(disp_hour), 1);
    check_eq("wrap_pm_kept", int'(disp_pm), 1);
    hit(DEC); rel(); hit(DEC); rel();
    check_eq("wrap_dec11", int'(disp_hour), 11);
    hit(COMMIT); rel();
    check_eq("wrap_commit", int'(hour_out), 23);

    // 24h wrap and ampm ignored
    two_four_format = 1'b1; hour_in = 6'd0;
    hit(START); rel();
    two_four_format = 1'b0;
    hit(DEC); rel();
    check_eq("24h_dec_wrap", int'(disp_hour), 23);
    hit(INC); rel();
    check_eq("24h_inc_wrap", int'(disp_hour), 0);
    hit(AMPM); rel();
    check_eq("24h_ampm_ignored", int'(disp_pm), 0);
    hit(COMMIT); rel();
    check_eq("24h_commit", int'(hour_out), 0);

    // Simultaneous edges
    two_four_format = 1'b1; hour_in = 6'd6;
    hit(START); rel();
    hit(INC | DEC); rel();
    check_eq("inc_dec_same", int'(disp_hour), 6);
    hit(COMMIT | INC);
    check_eq("commit_wins_out", int'(hour_out), 6);
    rel();
    hour_in = 6'd9;
    hit(START); rel();
    hit(INC); rel();
    hit(CANCEL | COMMIT);
    check_eq("cancel_wins_valid", int'(hour_valid), 0);
    check_eq("cancel_wins_editing", int'(editing), 0);
    rel();

    // Cancel leaves hour_out alone; display holds edited value
    hour_in = 6'd4;
    hit(START); rel(); hit(INC); rel();
    hit(CANCEL); rel();
    check_eq("cancel_out", int'(hour_out), 6);
    check_eq("cancel_disp_hold", int'(disp_hour), 5);

    // Reset mid-edit
    hit(START); rel(); hit(INC);
    mid_reset();
    check_eq("rst_mid_out", int'(hour_out), 7);
    rel();

    // Out-of-range seed
    two_four_format = 1'b0; hour_in = 6'd30;
    hit(START); rel();
    check_eq("bad_seed_12h", int'(disp_hour), 12);
    hit(CANCEL); rel();
    two_four_format = 1'b1;
    hit(START); rel();
    check_eq("bad_seed_24h", int'(disp_hour), 0);
    hit(CANCEL); rel();

    // Randomized buttons, formats and seeds
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(299) == 0) begin
        btn = '0;
        mid_reset();
      end else begin
        for (int b = 0; b < 6; b++) btn[b] = ($urandom_range(3) == 0);
        hour_in         = 6'($urandom_range(31));
        two_four_format = 1'($urandom_range(1));
        step();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
